// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Watches a multiplexed, active-low seven-segment display bus and recovers
// the hex digit shown on each digit position. A bus pattern is only captured
// once it has stayed unchanged for STABLE_CYCLES consecutive samples, so
// scan transitions and short glitches never reach the outputs.
//
// Parameters
//   DIGITS         number of multiplexed positions (1..8)
//   STABLE_CYCLES  identical consecutive samples needed before capture (>= 2)
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   cathodes     segment lines a..g (bit 0 = a), active-low
//   dp           decimal-point line, active-low
//   anodes       digit enables, active-low, bit i = position i
//   digit_val    decoded nibble per position, position i at [4i+3:4i]
//   digit_dp     decimal point lit per position (1 = lit)
//   digit_ok     last capture of the position was a valid hex glyph
//   frame_valid  one-cycle pulse when every position has been captured
//   anode_err    sticky: a stable pattern had more than one anode low
//
// seg7_scan_decoder_chk holds the structural assertions for the decoder.
// -----------------------------------------------------------------------------

module seg7_scan_decoder_chk #(
  parameter int DIGITS = 4
) (
  input logic              clk,
  input logic              reset,
  input logic              capture,
  input logic [DIGITS-1:0] sel,
  input logic              frame_valid
);

  // A capture may only ever address exactly one digit position.
  a_capture_onehot: assert property (@(posedge clk) disable iff (!reset)
    capture |-> $onehot(sel));

  // Frame completion is a single-cycle pulse.
  a_frame_single: assert property (@(posedge clk) disable iff (!reset)
    frame_valid |=> !frame_valid);

endmodule

module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            cathodes,
  input  logic                  dp,
  input  logic [DIGITS-1:0]     anodes,
  output logic [4*DIGITS-1:0]   digit_val,
  output logic [DIGITS-1:0]     digit_dp,
  output logic [DIGITS-1:0]     digit_ok,
  output logic                  frame_valid,
  output logic                  anode_err
);

  localparam int SW = DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_TERM = CW'(STABLE_CYCLES - 1);
  // Count value from which the next identical sample completes the window.
  localparam logic [CW-1:0] CNT_PRE  = CW'(STABLE_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Maps an active-low g..a segment pattern to {valid, nibble}.
  // Anything outside the sixteen hex glyphs (blank included) is invalid.
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1000000: res = {1'b1, 4'h0};
      7'b1111001: res = {1'b1, 4'h1};
      7'b0100100: res = {1'b1, 4'h2};
      7'b0110000: res = {1'b1, 4'h3};
      7'b0011001: res = {1'b1, 4'h4};
      7'b0010010: res = {1'b1, 4'h5};
      7'b0000010: res = {1'b1, 4'h6};
      7'b1111000: res = {1'b1, 4'h7};
      7'b0000000: res = {1'b1, 4'h8};
      7'b0010000: res = {1'b1, 4'h9};
      7'b0001000: res = {1'b1, 4'hA};
      7'b0000011: res = {1'b1, 4'hB};
      7'b1000110: res = {1'b1, 4'hC};
      7'b0100001: res = {1'b1, 4'hD};
      7'b0000110: res = {1'b1, 4'hE};
      7'b0001110: res = {1'b1, 4'hF};
      default:    res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  // Number of enabled (low) anode lines.
  function automatic logic [3:0] count_low(input logic [DIGITS-1:0] an);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (an[i] == 1'b0) begin
        n = n + 4'd1;
      end
    end
    return n;
  endfunction

  logic [SW-1:0]     sample_s;
  logic [SW-1:0]     held_r;
  logic              changed_s;
  logic [CW-1:0]     count_r;
  logic              at_pre_s;
  state_e            state_r;
  state_e            state_next_s;
  logic [3:0]        low_cnt_s;
  logic              one_low_s;
  logic              multi_low_s;
  logic [DIGITS-1:0] sel_s;
  logic [4:0]        glyph_s;
  logic              capture_s;
  logic              err_set_s;
  logic [DIGITS-1:0] seen_r;
  logic [DIGITS-1:0] seen_upd_s;
  logic              frame_done_s;

  logic [4*DIGITS-1:0] digit_val_r;
  logic [DIGITS-1:0]   digit_dp_r;
  logic [DIGITS-1:0]   digit_ok_r;
  logic                frame_valid_r;
  logic                anode_err_r;

  assign sample_s    = {anodes, dp, cathodes};
  assign changed_s   = (sample_s != held_r);
  assign at_pre_s    = (count_r == CNT_PRE);
  assign low_cnt_s   = count_low(sample_s[SW-1:8]);
  assign one_low_s   = (low_cnt_s == 4'd1);
  assign multi_low_s = (low_cnt_s > 4'd1);
  // With exactly one anode low this is a one-hot mask of the target position.
  assign sel_s       = ~sample_s[SW-1:8];
  assign glyph_s     = glyph_decode(sample_s[6:0]);

  // The seen bit set by this capture counts towards completing the frame.
  assign seen_upd_s   = seen_r | sel_s;
  assign frame_done_s = &seen_upd_s;

  assign digit_val   = digit_val_r;
  assign digit_dp    = digit_dp_r;
  assign digit_ok    = digit_ok_r;
  assign frame_valid = frame_valid_r;
  assign anode_err   = anode_err_r;

  // Held sample and stability counter: any change restarts the window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      held_r  <= {SW{1'b1}};
      count_r <= {CW{1'b0}};
    end else if (changed_s) begin
      held_r  <= sample_s;
      count_r <= {CW{1'b0}};
    end else if (count_r != CNT_TERM) begin
      held_r  <= held_r;
      count_r <= count_r + CW'(1);
    end else begin
      held_r  <= held_r;
      count_r <= count_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: a bus change always wins over a pending capture.
  always_comb begin
    state_next_s = state_r;
    if (changed_s) begin
      if (one_low_s) begin
        state_next_s = ST_TRACK;
      end else begin
        state_next_s = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = ST_IDLE;
        ST_TRACK: begin
          if (at_pre_s) begin
            state_next_s = ST_HOLD;
          end else begin
            state_next_s = ST_TRACK;
          end
        end
        ST_HOLD: state_next_s = ST_HOLD;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: capture strobe in TRACK, error strobe for a stable multi-anode bus.
  always_comb begin
    capture_s = 1'b0;
    err_set_s = 1'b0;
    if (!changed_s && at_pre_s) begin
      case (state_r)
        ST_TRACK: capture_s = 1'b1;
        ST_IDLE:  err_set_s = multi_low_s;
        ST_HOLD:  capture_s = 1'b0;
        default: begin
          capture_s = 1'b0;
          err_set_s = 1'b0;
        end
      endcase
    end else begin
      capture_s = 1'b0;
      err_set_s = 1'b0;
    end
  end

  // Per-position capture registers, frame tracking and frame pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_val_r   <= {(4*DIGITS){1'b0}};
      digit_dp_r    <= {DIGITS{1'b0}};
      digit_ok_r    <= {DIGITS{1'b0}};
      seen_r        <= {DIGITS{1'b0}};
      frame_valid_r <= 1'b0;
    end else if (capture_s) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_s[i]) begin
          digit_val_r[4*i +: 4] <= glyph_s[3:0];
          digit_ok_r[i]         <= glyph_s[4];
          digit_dp_r[i]         <= ~sample_s[7];
        end else begin
          digit_val_r[4*i +: 4] <= digit_val_r[4*i +: 4];
          digit_ok_r[i]         <= digit_ok_r[i];
          digit_dp_r[i]         <= digit_dp_r[i];
        end
      end
      if (frame_done_s) begin
        seen_r <= {DIGITS{1'b0}};
      end else begin
        seen_r <= seen_upd_s;
      end
      frame_valid_r <= frame_done_s;
    end else begin
      digit_val_r   <= digit_val_r;
      digit_dp_r    <= digit_dp_r;
      digit_ok_r    <= digit_ok_r;
      seen_r        <= seen_r;
      frame_valid_r <= 1'b0;
    end
  end

  // Sticky multi-anode error flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      anode_err_r <= 1'b0;
    end else if (err_set_s) begin
      anode_err_r <= 1'b1;
    end else begin
      anode_err_r <= anode_err_r;
    end
  end

  seg7_scan_decoder_chk #(
    .DIGITS (DIGITS)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .capture     (capture_s),
    .sel         (sel_s),
    .frame_valid (frame_valid_r)
  );

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the seven-segment display encoder: monitors a multiplexed, active-low cathode/anode display bus and recovers the hex digit shown on each position. Each digit is captured only after the bus has been stable for a programmable number of cycles, invalid patterns are flagged, and a pulse marks every completed frame. It sits on the board-test and loopback path, observing the display pins, so self-checks can read back what the display is showing.

## Interface
- `DIGITS`, default 4: number of multiplexed digit positions (1–8).
- `STABLE_CYCLES`, default 4: consecutive identical samples required before capture (minimum 2).
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cathodes`  in  7  segment lines, active-low; bit 0 = a … bit 6 = g.
- `dp`  in  1  decimal-point line, active-low.
- `anodes`  in  DIGITS  digit enables, active-low; bit i selects position i.
- `digit_val`  out  4*DIGITS  decoded nibble per position; position i is in bits [4i+3:4i].
- `digit_dp`  out  DIGITS  decimal point lit (1 = lit) per position.
- `digit_ok`  out  DIGITS  1 = last capture matched a valid hex glyph.
- `frame_valid`  out  1  one-cycle pulse when every position has been captured since the last pulse.
- `anode_err`  out  1  sticky: a stable pattern had more than one anode low.

## Operation
- Sample vector S = {anodes, dp, cathodes}; the raw input is compared every cycle against held sample S_h.
- Stability counter: if input ≠ S_h, then S_h ← input and count ← 0. Otherwise count increments and saturates at STABLE_CYCLES-1. Counter width is clog2(STABLE_CYCLES).
- FSM states:
  - IDLE: no capture armed.
  - TRACK: exactly one anode low, counting.
  - HOLD: captured, waiting for the bus to change.
- Any input change goes to TRACK if exactly one bit of the new anodes is 0, otherwise to IDLE.
- TRACK → HOLD when count reaches STABLE_CYCLES-1 with input == S_h. That edge performs the capture into position idx, the index of the low anode.
- HOLD persists while the input equals S_h; exactly one capture occurs per stable period.
- IDLE with more than one anode low: once the bus has been stable for STABLE_CYCLES samples, set `anode_err`. No capture. All anodes high (blank) is legal and has no effect.
- Capture action:
  - `digit_dp[idx]` ← ~dp.
  - Cathode pattern is matched against the glyph table. On a match, `digit_val[idx]` ← nibble and `digit_ok[idx]` ← 1. On no match (including blank 1111111), `digit_val[idx]` ← 0 and `digit_ok[idx]` ← 0.
  - seen[idx] ← 1.
- Glyph table (g…a): 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
- Frame completion: if the capture makes seen all-ones, including the bit set on the same edge, then `frame_valid` pulses and seen clears to 0. Recapturing a position before the frame completes overwrites its outputs and does not pulse.
- `anode_err` clears only on reset.

## Timing
- Reset values:
  - `digit_val` = 0, `digit_dp` = 0, `digit_ok` = 0.
  - `frame_valid` = 0, `anode_err` = 0.
  - seen = 0, count = 0, FSM = IDLE, S_h = all-ones (blank).
- Capture latency: for a new pattern present at rising edges E0 … E0+STABLE_CYCLES-1, outputs update at edge E0+STABLE_CYCLES-1. That is, they are valid STABLE_CYCLES-1 cycles after the first edge that saw the pattern.
- `frame_valid` is registered and high for exactly one cycle, coincident with the outputs of the completing capture.
- A glitch lasting fewer than STABLE_CYCLES edges produces no capture and leaves all outputs unchanged.
- Reset asserted mid-track or mid-frame aborts the pending capture and discards the partial frame. The first capture after reset requires a full STABLE_CYCLES window.
- A bus change on the same edge where the count would reach its terminal value aborts the capture; the change wins.
- Outputs hold their values indefinitely between captures.

## Test plan
- Scan digits 1, 2, A, F on anodes 1110, 1101, 1011, 0111, each held 8 cycles (STABLE_CYCLES=4) -> `digit_val` = 0xFA21, `digit_ok` = 1111, exactly one `frame_valid` pulse, on the digit-3 capture edge.
- Hold pattern 0100100 with anode 1110 for exactly 3 edges, then blank -> no capture; `digit_ok`[0] stays 0 and no `frame_valid`.
- Apply cathodes 1010101 (no glyph) on digit 2 with dp = 0 -> `digit_ok`[2] = 0, `digit_val`[11:8] = 0, `digit_dp`[2] = 1.
- Drive anodes 1100 stable for 4 cycles -> `anode_err` = 1 and remains 1 through later valid frames until reset.
- Capture digits 0 and 1, then assert reset for 1 cycle, then scan all 4 digits -> all outputs return to 0 during reset; `frame_valid` fires only after all four post-reset captures.
- Rescan digit 0 twice before completing the frame -> the second value overwrites the first, and a single `frame_valid` fires after digit 3.
